cpu_trace_buffer: RTL
=====================

Name: cpu_trace_buffer

Overview:
Parametrised on-chip trace capture unit for the LEGv8 CPU. It records per-cycle CPU state (counter/PC, instruction, read1, read2, ALU output, memory data) into a circular buffer. Capture stops a programmable number of samples after a trigger, and the buffer is then drained oldest-first through a valid/ready port. It replaces display-based tracing with a synthesizable, bench- and hardware-usable monitor sitting beside the cpu core.

Parameters:
DATA_WIDTH, 64, width of pc/read1/read2/alu_out/mem_data
INST_WIDTH, 32, instruction width (must be >= 11)
DEPTH, 16, buffer entries; power of 2, >= 2
POST_TRIG, 4, samples stored after the trigger sample; legal range 0..DEPTH-1

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
arm  in  1  start or restart capture (single-cycle pulse)
trig_mode  in  2  0 = first sample, 1 = pc match, 2 = opcode match, 3 = external
trig_pc  in  DATA_WIDTH  pc compare value (mode 1)
trig_opcode  in  11  compared against instruction[INST_WIDTH-1 -: 11] (mode 2)
trig_in  in  1  external trigger, sampled with sample_valid (mode 3)
sample_valid  in  1  the sample fields below are valid this cycle
pc, read1, read2, alu_out, mem_data  in  DATA_WIDTH each  CPU state
instruction  in  INST_WIDTH  current instruction
rd_ready  in  1  consumer accepts the current readout entry
rd_valid  out  1  readout entry available
rd_pc, rd_read1, rd_read2, rd_alu_out, rd_mem_data  out  DATA_WIDTH each  entry fields
rd_instruction  out  INST_WIDTH  entry field
trig_offset  out  $clog2(DEPTH)  readout index of the trigger sample
entries  out  $clog2(DEPTH)+1  valid entries currently held
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE

Behaviour:
- Reset (async, reset_n=0): state=IDLE; wr_ptr, rd_ptr, entries, post_cnt, trig_offset = 0; rd_valid=0. Buffer contents are not reset; rd_* fields are don't-care while rd_valid=0.
- IDLE: nothing is captured. arm=1 moves to ARMED next edge with wr_ptr=0 and entries=0. A sample_valid on the arm cycle is not captured.
- ARMED: each sample_valid writes {pc,instruction,read1,read2,alu_out,mem_data} at wr_ptr. wr_ptr increments mod DEPTH. entries saturates at DEPTH; the oldest entry is overwritten when full.
- The trigger is evaluated on the same valid sample, which is always written:
  - mode 0: always true.
  - mode 1: pc==trig_pc.
  - mode 2: opcode field == trig_opcode.
  - mode 3: trig_in=1.
  - On a hit with POST_TRIG=0, go to DONE. Otherwise load post_cnt=POST_TRIG and go to POST.
- POST: each valid sample is written and post_cnt decrements. The sample that takes post_cnt from 1 to 0 is written, then the state moves to DONE. Triggers are ignored in POST.
- On entry to DONE:
  - trig_offset = entries_final - 1 - POST_TRIG.
  - rd_ptr = (wr_ptr_final - entries_final) mod DEPTH, i.e. the oldest entry.
- DONE: sample_valid is ignored.
  - rd_valid = (entries != 0). rd_* outputs combinationally reflect mem[rd_ptr].
  - rd_valid && rd_ready pops: rd_ptr++ mod DEPTH, entries--.
  - The pop of the last entry returns the block to IDLE the next edge.
- Readout order is strictly oldest to newest. The trigger entry appears at index trig_offset.
- arm in ARMED, POST or DONE: restart as described from IDLE. Pointers and entries are cleared, and any undrained data is discarded. arm has priority over a simultaneous pop or sample write.
- entries never exceeds DEPTH. No data is ever lost before the trigger except by overwrite of the oldest entry.
- There is no latency between pop and the next entry: the following entry is visible the cycle after the pop edge.

Test Plan:
1. DEPTH=8, POST_TRIG=2, mode 0. Arm, then 5 valid samples with pc=0,4,8,12,16 → DONE after the 3rd sample; entries=3; trig_offset=0; readout pc=0,4,8, then IDLE.
2. Mode 1, trig_pc=40. Samples pc=0,4,…,60 continuously → trigger at pc=40 after 11 samples (buffer wrapped); DONE after pc=48; entries=8; readout pc=20..48; trig_offset=5.
3. Mode 2, trig_opcode=11'h7C2 (LDUR). LDUR is the 3rd instruction; sample_valid low on alternate cycles → gaps are not recorded; entries=5; trig_offset=2; rd_instruction[31:21] at index 2 = 7C2.
4. Readout with rd_ready toggling 1,0,1,1 → pops only on ready cycles; rd_valid falls after the last pop; state=0.
5. Reset_n pulsed low mid-POST → all outputs 0 immediately (async). After release, sample_valid with no arm → nothing captured; entries=0.
6. Arm re-issued in DONE with 3 entries undrained, then mode 3 with trig_in on the 1st sample, POST_TRIG=0 → entries=1, trig_offset=0, old data gone.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Trace capture unit for the LEGv8 core: circular sample buffer with a programmable
// trigger and post-trigger depth, drained oldest-first through a valid/ready port.
module cpu_trace_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int POST_TRIG  = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       arm,
    input  logic [1:0]                 trig_mode,
    input  logic [DATA_WIDTH-1:0]      trig_pc,
    input  logic [10:0]                trig_opcode,
    input  logic                       trig_in,
    input  logic                       sample_valid,
    input  logic [DATA_WIDTH-1:0]      pc,
    input  logic [INST_WIDTH-1:0]      instruction,
    input  logic [DATA_WIDTH-1:0]      read1,
    input  logic [DATA_WIDTH-1:0]      read2,
    input  logic [DATA_WIDTH-1:0]      alu_out,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_pc,
    output logic [INST_WIDTH-1:0]      rd_instruction,
    output logic [DATA_WIDTH-1:0]      rd_read1,
    output logic [DATA_WIDTH-1:0]      rd_read2,
    output logic [DATA_WIDTH-1:0]      rd_alu_out,
    output logic [DATA_WIDTH-1:0]      rd_mem_data,
    output logic [$clog2(DEPTH)-1:0]   trig_offset,
    output logic [$clog2(DEPTH):0]     entries,
    output logic [1:0]                 state
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = 5 * DATA_WIDTH + INST_WIDTH;
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        entries_q, entries_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW-1:0]      trig_offset_q, trig_offset_d;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_entry;
    logic               wr_en;
    logic               hit;
    logic [AW-1:0]      wr_ptr_inc;
    logic [AW:0]        entries_inc;

    assign wr_data = {pc, instruction, read1, read2, alu_out, mem_data};

    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            2'd0: hit = 1'b1;
            2'd1: hit = (pc == trig_pc);
            2'd2: hit = (instruction[INST_WIDTH-1 -: 11] == trig_opcode);
            2'd3: hit = trig_in;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        entries_d     = entries_q;
        post_cnt_d    = post_cnt_q;
        trig_offset_d = trig_offset_q;
        wr_en         = 1'b0;
        wr_ptr_inc    = wr_ptr_q + 1'b1;
        entries_inc   = (entries_q == FULL) ? entries_q : entries_q + 1'b1;

        if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            entries_d  = '0;
            post_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED, POST: begin
                    if (sample_valid) begin
                        wr_en     = 1'b1;
                        wr_ptr_d  = wr_ptr_inc;
                        entries_d = entries_inc;
                        if (state_q == ARMED && hit && POST_TRIG != 0) begin
                            state_d    = POST;
                            post_cnt_d = POST_INIT;
                        end else if ((state_q == ARMED && hit) ||
                                     (state_q == POST && post_cnt_q == AW'(1))) begin
                            // Oldest entry and trigger index derive from the post-write
                            // pointer/count; a full buffer truncates entries to 0 mod DEPTH.
                            state_d       = DONE;
                            rd_ptr_d      = wr_ptr_inc - entries_inc[AW-1:0];
                            trig_offset_d = entries_inc[AW-1:0] - AW'(1) - POST_INIT;
                        end else if (state_q == POST) begin
                            post_cnt_d = post_cnt_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (rd_valid && rd_ready) begin
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        entries_d = entries_q - 1'b1;
                        if (entries_q == (AW+1)'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            entries_q     <= '0;
            post_cnt_q    <= '0;
            trig_offset_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            entries_q     <= entries_d;
            post_cnt_q    <= post_cnt_d;
            trig_offset_q <= trig_offset_d;
        end
    end

    // Buffer storage carries no reset; contents are only meaningful while rd_valid is high.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        rd_entry = mem_q[rd_ptr_q];
        {rd_pc, rd_instruction, rd_read1, rd_read2, rd_alu_out, rd_mem_data} = rd_entry;
    end

    assign rd_valid    = (state_q == DONE) && (entries_q != '0);
    assign trig_offset = trig_offset_q;
    assign entries     = entries_q;
    assign state       = state_q;

endmodule
